// File: rtl/vga_sync_decoder_if.sv
// Interface between a VGA source and the sync decoder. It carries the sync/RGB stream
// in one direction and the recovered pixel timing and status in the other.
interface vga_sync_decoder_if;
  logic        VGA_HS;
  logic        VGA_VS;
  logic [7:0]  VGA_R;
  logic [7:0]  VGA_G;
  logic [7:0]  VGA_B;
  logic [9:0]  pixel_x;
  logic [9:0]  pixel_y;
  logic        pixel_valid;
  logic [7:0]  pixel_r;
  logic [7:0]  pixel_g;
  logic [7:0]  pixel_b;
  logic        locked;
  logic        h_error;
  logic        v_error;
  logic [7:0]  error_count;
  logic        frame_done;
  logic [18:0] lit_count;

  modport master (
    output VGA_HS, VGA_VS, VGA_R, VGA_G, VGA_B,
    input  pixel_x, pixel_y, pixel_valid, pixel_r, pixel_g, pixel_b,
    input  locked, h_error, v_error, error_count, frame_done, lit_count
  );

  modport slave (
    input  VGA_HS, VGA_VS, VGA_R, VGA_G, VGA_B,
    output pixel_x, pixel_y, pixel_valid, pixel_r, pixel_g, pixel_b,
    output locked, h_error, v_error, error_count, frame_done, lit_count
  );
endinterface

// File: rtl/vga_sync_decoder.sv
// Receive-side VGA monitor: recovers pixel coordinates from HS/VS, checks line/frame
// timing, tracks lock (SEARCH -> ACQUIRE -> LOCKED) and counts lit pixels per frame.
module vga_sync_decoder #(
  parameter int H_TOTAL     = 800,
  parameter int H_SYNC      = 96,
  parameter int H_ACT_START = 144,
  parameter int H_ACTIVE    = 640,
  parameter int V_TOTAL     = 525,
  parameter int V_SYNC      = 2,
  parameter int V_ACT_START = 35,
  parameter int V_ACTIVE    = 480
) (
  input logic               VGA_CLK,
  input logic               reset,
  vga_sync_decoder_if.slave vga
);
  typedef enum logic [1:0] {SEARCH, ACQUIRE, LOCKED} state_t;

  localparam logic [10:0] H_TOTAL_C = 11'(H_TOTAL);
  localparam logic [10:0] H_SYNC_C  = 11'(H_SYNC);
  localparam logic [10:0] V_TOTAL_C = 11'(V_TOTAL);
  localparam logic [10:0] V_SYNC_C  = 11'(V_SYNC);
  localparam logic [10:0] H_LO_C    = 11'(H_ACT_START);
  localparam logic [10:0] H_HI_C    = 11'(H_ACT_START + H_ACTIVE);
  localparam logic [10:0] V_LO_C    = 11'(V_ACT_START);
  localparam logic [10:0] V_HI_C    = 11'(V_ACT_START + V_ACTIVE);
  localparam logic [9:0]  H_OFS_C   = 10'(H_ACT_START);
  localparam logic [9:0]  V_OFS_C   = 10'(V_ACT_START);

  state_t      state_q, state_d;
  logic        hs_q, vs_q;
  logic [9:0]  hc_q, hc_d, vc_q, vc_d;
  logic [7:0]  r_q, g_q, b_q;
  logic        h_err_q, h_err_d, v_err_q, v_err_d;
  logic        frame_done_q, frame_done_d;
  logic [7:0]  err_cnt_q, err_cnt_d;
  logic [18:0] lit_acc_q, lit_acc_d, lit_cnt_q, lit_cnt_d;

  logic        hf, hr, vf, vr, frame_edge, checking;
  logic [10:0] hc_p1, vc_p1;
  logic        in_window, pix_valid, lit_pix;
  logic [8:0]  err_sum;

  assign hf         = hs_q & ~vga.VGA_HS;
  assign hr         = ~hs_q & vga.VGA_HS;
  assign vf         = vs_q & ~vga.VGA_VS;
  assign vr         = ~vs_q & vga.VGA_VS;
  assign frame_edge = vf & hf;
  assign checking   = (state_q != SEARCH);

  // 11-bit sums so a saturated 1023 counter never aliases onto a legal total
  assign hc_p1 = {1'b0, hc_q} + 11'd1;
  assign vc_p1 = {1'b0, vc_q} + 11'd1;

  always_comb begin
    hc_d = hf ? 10'd0 : ((hc_q == 10'h3FF) ? hc_q : hc_q + 10'd1);
    vc_d = vc_q;
    if (frame_edge)
      vc_d = 10'd0;
    else if (hf)
      vc_d = (vc_q == 10'h3FF) ? vc_q : vc_q + 10'd1;
  end

  always_comb begin
    h_err_d = 1'b0;
    v_err_d = 1'b0;
    if (checking) begin
      if (hf && hc_p1 != H_TOTAL_C) h_err_d = 1'b1;
      if (hr && hc_p1 != H_SYNC_C)  h_err_d = 1'b1;
      if ((vf || vr) && !hf)        v_err_d = 1'b1;
      if (vf && hf && vc_p1 != V_TOTAL_C) v_err_d = 1'b1;
      if (vr && hf && vc_p1 != V_SYNC_C)  v_err_d = 1'b1;
    end
  end

  assign in_window = ({1'b0, hc_q} >= H_LO_C) && ({1'b0, hc_q} < H_HI_C) &&
                     ({1'b0, vc_q} >= V_LO_C) && ({1'b0, vc_q} < V_HI_C);
  assign pix_valid = in_window && (state_q == LOCKED);
  assign lit_pix   = pix_valid && ((r_q | g_q | b_q) != 8'd0);
  assign err_sum   = {1'b0, err_cnt_q} + 9'(h_err_d) + 9'(v_err_d);

  always_comb begin
    state_d      = state_q;
    frame_done_d = 1'b0;
    lit_acc_d    = lit_acc_q + 19'(lit_pix);
    lit_cnt_d    = lit_cnt_q;
    err_cnt_d    = err_sum[8] ? 8'hFF : err_sum[7:0];
    case (state_q)
      SEARCH: begin
        if (frame_edge) state_d = ACQUIRE;
      end
      ACQUIRE, LOCKED: begin
        if (frame_edge) begin
          frame_done_d = 1'b1;
          lit_cnt_d    = lit_acc_q + 19'(lit_pix);
          lit_acc_d    = 19'd0;
        end
        // an error on an aligned frame edge still marks a usable frame start
        if (h_err_d || v_err_d)
          state_d = frame_edge ? ACQUIRE : SEARCH;
        else if (frame_edge)
          state_d = LOCKED;
      end
      default: state_d = SEARCH;
    endcase
    if (state_d == SEARCH && state_q != SEARCH) lit_acc_d = 19'd0;
  end

  always_ff @(posedge VGA_CLK or posedge reset) begin
    if (reset) begin
      state_q      <= SEARCH;
      hs_q         <= 1'b1;
      vs_q         <= 1'b1;
      hc_q         <= 10'd0;
      vc_q         <= 10'd0;
      r_q          <= 8'd0;
      g_q          <= 8'd0;
      b_q          <= 8'd0;
      h_err_q      <= 1'b0;
      v_err_q      <= 1'b0;
      frame_done_q <= 1'b0;
      err_cnt_q    <= 8'd0;
      lit_acc_q    <= 19'd0;
      lit_cnt_q    <= 19'd0;
    end else begin
      state_q      <= state_d;
      hs_q         <= vga.VGA_HS;
      vs_q         <= vga.VGA_VS;
      hc_q         <= hc_d;
      vc_q         <= vc_d;
      r_q          <= vga.VGA_R;
      g_q          <= vga.VGA_G;
      b_q          <= vga.VGA_B;
      h_err_q      <= h_err_d;
      v_err_q      <= v_err_d;
      frame_done_q <= frame_done_d;
      err_cnt_q    <= err_cnt_d;
      lit_acc_q    <= lit_acc_d;
      lit_cnt_q    <= lit_cnt_d;
    end
  end

  assign vga.pixel_valid = pix_valid;
  assign vga.pixel_x     = pix_valid ? (hc_q - H_OFS_C) : 10'd0;
  assign vga.pixel_y     = pix_valid ? (vc_q - V_OFS_C) : 10'd0;
  assign vga.pixel_r     = r_q;
  assign vga.pixel_g     = g_q;
  assign vga.pixel_b     = b_q;
  assign vga.locked      = (state_q == LOCKED);
  assign vga.h_error     = h_err_q;
  assign vga.v_error     = v_err_q;
  assign vga.error_count = err_cnt_q;
  assign vga.frame_done  = frame_done_q;
  assign vga.lit_count   = lit_cnt_q;
endmodule

// File: tb/tb_vga_sync_decoder.sv
// Bench for vga_sync_decoder on a reduced 40x30 raster (24x20 active) so that many
// frames fit in a short run; a background generator drives the stream with injectable faults.
module tb_vga_sync_decoder;
  localparam int HT = 40, HSW = 6, HAS = 10, HA = 24;
  localparam int VT = 30, VSW = 2, VAS = 5, VA = 20;
  localparam int LIT_PAT = 176;  // 4x4 block + 2-wide border on 24x20: 16 + (480 - 20*16)

  logic VGA_CLK;
  logic reset;
  vga_sync_decoder_if bus ();

  vga_sync_decoder #(
    .H_TOTAL(HT), .H_SYNC(HSW), .H_ACT_START(HAS), .H_ACTIVE(HA),
    .V_TOTAL(VT), .V_SYNC(VSW), .V_ACT_START(VAS), .V_ACTIVE(VA)
  ) dut (
    .VGA_CLK (VGA_CLK),
    .reset   (reset),
    .vga     (bus)
  );

  initial begin
    VGA_CLK = 1'b0;
    forever #5 VGA_CLK = ~VGA_CLK;
  end

  int total = 0, bad = 0;
  int gx, gy, pgx, pgy, fcnt;
  int cur_hlen, cur_hsw, cur_vlen;
  int req_hlen, req_hsw, req_vlen;
  int pat;

  function automatic logic [23:0] pat_rgb(input int pt, input int x, input int y);
    if (pt == 0) return 24'h000000;
    if (x >= 8 && x <= 11 && y >= 8 && y <= 11) return 24'hFFFF00;
    if (x < 2 || x > HA - 3 || y < 2 || y > VA - 3) return 24'hFF0000;
    return 24'h000000;
  endfunction

  task automatic drive();
    bit act;
    logic [23:0] c;
    bus.VGA_HS = (gx < cur_hsw) ? 1'b0 : 1'b1;
    bus.VGA_VS = (gy < VSW) ? 1'b0 : 1'b1;
    act = (gx >= HAS) && (gx < HAS + HA) && (gy >= VAS) && (gy < VAS + VA);
    c = act ? pat_rgb(pat, gx - HAS, gy - VAS) : 24'h000000;
    {bus.VGA_R, bus.VGA_G, bus.VGA_B} = c;
  endtask

  // raster generator; pgx/pgy name the position sampled at the latest rising edge
  initial begin
    gx = 0; gy = 0; pgx = -1; pgy = -1; fcnt = 0; pat = 0;
    cur_hlen = HT; cur_hsw = HSW; cur_vlen = VT;
    req_hlen = 0; req_hsw = 0; req_vlen = 0;
    drive();
    forever begin
      @(posedge VGA_CLK);
      #1;
      pgx = gx; pgy = gy;
      gx++;
      if (gx >= cur_hlen) begin
        gx = 0; gy++;
        if (gy >= cur_vlen) begin
          gy = 0; fcnt++;
          cur_vlen = (req_vlen != 0) ? req_vlen : VT;
          req_vlen = 0;
        end
        cur_hlen = (req_hlen != 0) ? req_hlen : HT;
        cur_hsw  = (req_hsw != 0) ? req_hsw : HSW;
        req_hlen = 0; req_hsw = 0;
      end
      drive();
    end
  end

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (frame %0d x %0d y %0d)", name, act, exp, fcnt, pgx, pgy);
    end
  endtask

  task automatic wait_pos(input int x, input int y, input int f);
    for (int i = 0; i < 20000; i++) begin
      @(negedge VGA_CLK);
      if (pgx == x && pgy == y && (f < 0 || fcnt == f)) return;
    end
    $display("FAIL wait_pos: got timeout expected position %0d,%0d", x, y);
    $fatal(1, "generator position never reached");
  endtask

  task automatic wait_sig(input int which, input int limit, output bit hit);
    hit = 1'b0;
    for (int i = 0; i < limit; i++) begin
      @(negedge VGA_CLK);
      case (which)
        0:       hit = bus.frame_done;
        1:       hit = bus.h_error;
        default: hit = bus.v_error;
      endcase
      if (hit) break;
    end
  endtask

  task automatic check_frame_pixels();
    int f, nbad, lim, ex, ey;
    bit ev;
    logic [23:0] ec, gc;
    f = fcnt; nbad = 0; lim = 0;
    do begin
      @(negedge VGA_CLK);
      lim++;
      ev = (pgx >= HAS) && (pgx < HAS + HA) && (pgy >= VAS) && (pgy < VAS + VA);
      ex = ev ? pgx - HAS : 0;
      ey = ev ? pgy - VAS : 0;
      ec = ev ? pat_rgb(pat, ex, ey) : 24'h000000;
      gc = {bus.pixel_r, bus.pixel_g, bus.pixel_b};
      if (bus.pixel_valid !== ev || bus.pixel_x !== ex[9:0] || bus.pixel_y !== ey[9:0] || gc !== ec) begin
        if (nbad == 0)
          $display("first bad pixel at %0d,%0d: valid %0b x %0d y %0d rgb %06h, want %0b %0d %0d %06h",
                   pgx, pgy, bus.pixel_valid, bus.pixel_x, bus.pixel_y, gc, ev, ex, ey, ec);
        nbad++;
      end
    end while (fcnt == f && lim < 5000);
    check("frame_pixels", nbad, 0);
  endtask

  typedef struct {
    int gx;
    int gy;
    int valid;
    int px;
    int py;
  } vec_t;
  vec_t tbl[9];

  initial begin
    bit hit;
    int nbad;

    tbl[0] = '{10, 4, 0, 0, 0};
    tbl[1] = '{9, 5, 0, 0, 0};
    tbl[2] = '{10, 5, 1, 0, 0};
    tbl[3] = '{33, 5, 1, 23, 0};
    tbl[4] = '{34, 5, 0, 0, 0};
    tbl[5] = '{20, 12, 1, 10, 7};
    tbl[6] = '{10, 24, 1, 0, 19};
    tbl[7] = '{33, 24, 1, 23, 19};
    tbl[8] = '{10, 25, 0, 0, 0};

    reset = 1'b1;
    repeat (3) @(negedge VGA_CLK);
    check("rst_locked", int'(bus.locked), 0);
    check("rst_valid", int'(bus.pixel_valid), 0);
    check("rst_err_cnt", int'(bus.error_count), 0);
    check("rst_lit", int'(bus.lit_count), 0);
    check("rst_frame_done", int'(bus.frame_done), 0);

    // nominal stream, reset released in frame 0 line 10
    wait_pos(20, 10, 0);
    reset = 1'b0;
    wait_pos(20, 1, 1);
    check("acq_not_locked", int'(bus.locked), 0);
    wait_sig(0, 3000, hit);
    check("lock1_seen", int'(hit), 1);
    check("lock1_frame", fcnt, 2);
    check("lock1_locked", int'(bus.locked), 1);
    check("lock1_errs", int'(bus.error_count), 0);

    foreach (tbl[i]) begin
      wait_pos(tbl[i].gx, tbl[i].gy, 2);
      check($sformatf("tbl%0d_valid", i), int'(bus.pixel_valid), tbl[i].valid);
      check($sformatf("tbl%0d_x", i), int'(bus.pixel_x), tbl[i].px);
      check($sformatf("tbl%0d_y", i), int'(bus.pixel_y), tbl[i].py);
    end

    wait_sig(0, 3000, hit);
    check("black_frame", fcnt, 3);
    check("black_lit", int'(bus.lit_count), 0);

    // block + border pattern
    pat = 1;
    check_frame_pixels();
    wait_sig(0, 3000, hit);
    check("pat_frame", fcnt, 4);
    check("pat_lit", int'(bus.lit_count), LIT_PAT);

    // one 39-clock line mid-frame
    wait_pos(20, 10, -1);
    req_hlen = HT - 1;
    wait_sig(1, 200, hit);
    check("short_line_herr", int'(hit), 1);
    check("short_line_pos", pgy * 10000 + pgx, 12 * 10000);
    check("short_line_verr", int'(bus.v_error), 0);
    check("short_line_locked", int'(bus.locked), 0);
    check("short_line_cnt", int'(bus.error_count), 1);
    pat = 0;
    wait_sig(0, 3000, hit);
    check("relock2_frame", fcnt, 6);
    check("relock2_locked", int'(bus.locked), 1);
    check("relock2_lit", int'(bus.lit_count), 0);

    // HS low for one clock too few
    wait_pos(20, 10, -1);
    req_hsw = HSW - 1;
    wait_sig(1, 200, hit);
    check("narrow_hs_herr", int'(hit), 1);
    check("narrow_hs_pos", pgy * 10000 + pgx, 11 * 10000 + (HSW - 1));
    check("narrow_hs_locked", int'(bus.locked), 0);
    check("narrow_hs_cnt", int'(bus.error_count), 2);
    wait_sig(0, 3000, hit);
    check("relock3_frame", fcnt, 8);
    check("relock3_locked", int'(bus.locked), 1);

    // frame 9: 29 lines, last line 39 clocks -> both errors on the aligned edge
    req_vlen = VT - 1;
    wait_pos(20, 27, 9);
    req_hlen = HT - 1;
    wait_sig(2, 3000, hit);
    check("short_frame_verr", int'(hit), 1);
    check("short_frame_frame", fcnt, 10);
    check("short_frame_pos", pgy * 10000 + pgx, 0);
    check("short_frame_herr", int'(bus.h_error), 1);
    check("short_frame_cnt", int'(bus.error_count), 4);
    check("short_frame_locked", int'(bus.locked), 0);
    check("short_frame_done", int'(bus.frame_done), 1);
    wait_sig(0, 3000, hit);
    check("reacq_frame", fcnt, 11);
    check("reacq_locked", int'(bus.locked), 1);

    // HS held high 1500 clocks: counter must saturate, never re-enter the window
    wait_pos(20, 10, -1);
    req_hlen = HSW + 1500;
    hit = 1'b0; nbad = 0;
    for (int i = 0; i < 3000 && !hit; i++) begin
      @(negedge VGA_CLK);
      if (bus.h_error) hit = 1'b1;
      else if (pgx >= HT && bus.pixel_valid) nbad++;
    end
    check("long_line_herr", int'(hit), 1);
    check("long_line_pos", pgy * 10000 + pgx, 12 * 10000);
    check("long_line_no_wrap", nbad, 0);
    check("long_line_cnt", int'(bus.error_count), 5);
    check("long_line_locked", int'(bus.locked), 0);
    pat = 1;
    wait_sig(0, 3000, hit);
    check("relock5_frame", fcnt, 13);
    check("relock5_locked", int'(bus.locked), 1);
    wait_sig(0, 3000, hit);
    check("relock5_lit_frame", fcnt, 14);
    check("relock5_lit", int'(bus.lit_count), LIT_PAT);

    // asynchronous reset mid active line
    wait_pos(20, 10, -1);
    check("pre_rst_valid", int'(bus.pixel_valid), 1);
    check("pre_rst_x", int'(bus.pixel_x), 10);
    check("pre_rst_y", int'(bus.pixel_y), 5);
    reset = 1'b1;
    #1;
    check("async_rst_valid", int'(bus.pixel_valid), 0);
    check("async_rst_locked", int'(bus.locked), 0);
    check("async_rst_x", int'(bus.pixel_x), 0);
    check("async_rst_lit", int'(bus.lit_count), 0);
    check("async_rst_cnt", int'(bus.error_count), 0);
    pat = 0;
    wait_pos(20, 12, -1);
    reset = 1'b0;
    wait_pos(20, 1, 15);
    check("post_rst_acq", int'(bus.locked), 0);
    wait_sig(0, 3000, hit);
    check("post_rst_frame", fcnt, 16);
    check("post_rst_locked", int'(bus.locked), 1);
    check("post_rst_cnt", int'(bus.error_count), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/vga_sync_decoder.md
Name: vga_sync_decoder

Overview:
- Receive-side counterpart of the VGA timing generator. Consumes VGA_HS, VGA_VS and 8-bit RGB and recovers pixel coordinates.
- Checks the 800x525 timing, tracks frame lock, and counts lit pixels per frame.
- Used as an in-fabric monitor in the top level and as the checker in game-screen benches (trail and border rendering).

Parameters:
H_TOTAL, 800, pixel clocks per line
H_SYNC, 96, HS low width in clocks
H_ACT_START, 144, first active column (sync plus back porch)
H_ACTIVE, 640, active columns
V_TOTAL, 525, lines per frame
V_SYNC, 2, VS low width in lines
V_ACT_START, 35, first active line
V_ACTIVE, 480, active lines

Ports:
VGA_CLK  in  1  pixel clock; all logic on its rising edge
reset  in  1  asynchronous, active-high reset
VGA_HS  in  1  horizontal sync, active low
VGA_VS  in  1  vertical sync, active low
VGA_R  in  8  red pixel data
VGA_G  in  8  green pixel data
VGA_B  in  8  blue pixel data
pixel_x  out  10  recovered column, 0..639, 0 when not valid
pixel_y  out  10  recovered row, 0..479, 0 when not valid
pixel_valid  out  1  locked and inside the active window
pixel_r  out  8  VGA_R delayed to align with pixel_x/pixel_y
pixel_g  out  8  VGA_G delayed to align with pixel_x/pixel_y
pixel_b  out  8  VGA_B delayed to align with pixel_x/pixel_y
locked  out  1  state is LOCKED
h_error  out  1  one-cycle pulse on a horizontal timing violation
v_error  out  1  one-cycle pulse on a vertical timing violation
error_count  out  8  saturating count of h_error plus v_error pulses
frame_done  out  1  one-cycle pulse at each aligned VS falling edge while in ACQUIRE or LOCKED
lit_count  out  19  pixel_valid cycles in the last frame with any RGB component nonzero

Behaviour:
- Reset (asynchronous, immediate): all outputs 0; hc=0, vc=0; state SEARCH; hs_q=1, vs_q=1 (idle high, so no false edge); internal lit accumulator 0.
- Edge detection uses hs_q/vs_q, which are VGA_HS/VGA_VS registered every cycle:
  - HF: hs_q=1 and VGA_HS=0
  - HR: hs_q=0 and VGA_HS=1
  - VF, VR: same definitions on VS.
- hc: on HF, hc<=0; otherwise hc<=hc+1, saturating at 1023 (no wrap).
- vc: on VF&HF, vc<=0; else on HF, vc<=vc+1, saturating at 1023; otherwise hold.
- Horizontal checks, active in ACQUIRE and LOCKED only:
  - HF with hc+1 != H_TOTAL -> h_error.
  - HR with hc+1 != H_SYNC -> h_error.
- Vertical checks, active in ACQUIRE and LOCKED only:
  - VF or VR without a simultaneous HF -> v_error.
  - VF&HF with vc+1 != V_TOTAL -> v_error.
  - VR&HF with vc+1 != V_SYNC -> v_error.
- If h_error and v_error fire in the same cycle, both pulse and error_count adds 2, saturating at 255.
- Lock state machine:
  - SEARCH: no checks. VF&HF -> ACQUIRE.
  - ACQUIRE: VF&HF with no error since entry -> LOCKED; frame_done pulses.
  - LOCKED: locked=1; VF&HF -> stay in LOCKED, frame_done pulses.
  - Any error in ACQUIRE or LOCKED: if the error cycle is VF&HF, go to ACQUIRE (that edge is a fresh frame start); otherwise go to SEARCH.
- Latency: one clock. hc/vc reflect input sampled on the previous edge.
  - pixel_x = hc-H_ACT_START and pixel_y = vc-V_ACT_START when hc in [144,783], vc in [35,514] and state=LOCKED.
  - Otherwise pixel_x, pixel_y and pixel_valid are 0.
  - Combinational from hc, vc and state.
- pixel_r/g/b: one register stage on VGA_R/G/B, so pixel data matches pixel_x/pixel_y in the same cycle.
- lit accumulator:
  - Increments on pixel_valid with (pixel_r|pixel_g|pixel_b)!=0.
  - At VF&HF in ACQUIRE or LOCKED, lit_count<=accumulator value including the current cycle, then accumulator<=0.
  - Cleared on any transition to SEARCH.
- Widths: comparisons use 11-bit sums (hc+1, vc+1) so the 1023+1 case does not alias.

Test Plan:
1. Nominal stream, 3 frames, all-black RGB, reset released during frame 0 line 10 -> SEARCH until frame 1 VS fall, then ACQUIRE; locked=1 at frame 2 VS fall; no errors. First pixel_valid at hc=144, vc=35 with pixel_x=0, pixel_y=0; last at pixel_x=639, pixel_y=479.
2. While LOCKED, one line of 799 clocks (mid-frame) -> h_error one cycle at the short HF, state SEARCH, locked=0, error_count=1. Relock after two further clean VS falls.
3. While LOCKED, HS low width 95 -> h_error at HR, error_count=1, SEARCH. Frame with 524 lines at VS fall -> v_error, state ACQUIRE (aligned edge), locked=0.
4. While LOCKED, an 8x8 yellow block at (216,240), 255,255,0, plus a border in red 255,0,0 where x<16 or x>623 or y<16 or y>463, on black -> lit_count=64+(307200-608*448)=64+34816=34880 at frame_done. pixel_r/g/b equal 255,255,0 exactly when pixel_x=216..223, pixel_y=240..247.
5. HS held high 1500 clocks while LOCKED -> hc saturates at 1023 (no wrap); h_error at next HF; SEARCH.
6. Assert reset mid-active-line while LOCKED, pixel_valid=1 -> pixel_valid, locked, pixel_x, lit_count and error_count all 0 before the next VGA_CLK edge. After release, relock requires SEARCH->ACQUIRE->LOCKED again.
